// File: rtl/owm_pkg.sv
// Shared definitions for the 1-Wire bus master: command op codes, FSM states
// and default slot/reset timing in clk cycles at 100 MHz.
package owm_pkg;

  localparam int unsigned OP_W = 2;

  // Command op codes carried on cmd_op
  typedef enum logic [OP_W-1:0] {
    OP_RST = 2'b00,
    OP_WR  = 2'b01,
    OP_RD  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  // Master FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_LOW   = 3'd1,
    RST_WAIT  = 3'd2,
    SLOT_LOW  = 3'd3,
    SLOT_WAIT = 3'd4
  } state_e;

  // Default timing (cycles at 100 MHz)
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned T_RSTL_DEF = 48000;
  localparam int unsigned T_PDS_DEF  = 7000;
  localparam int unsigned T_RSTH_DEF = 41000;
  localparam int unsigned T_LOW1_DEF = 600;
  localparam int unsigned T_LOW0_DEF = 6000;
  localparam int unsigned T_SMP_DEF  = 1500;
  localparam int unsigned T_SLOT_DEF = 6500;

endpackage

// File: rtl/owm_bus_master_if.sv
// Command/response handshake and DQ pad signals of the 1-Wire bus master.
//   cmd_valid/cmd_ready/cmd_op/cmd_bit : command request from the byte sequencer
//   rsp_valid/rsp_bit/bus_err          : completion pulse and result
//   busy                               : inverse of cmd_ready
//   data_in/data_out/data_out_oe       : raw DQ level and open-drain drive
// master : the bus master itself; slave : sequencer and pad side.
interface owm_bus_master_if;
  import owm_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic            cmd_bit;
  logic            rsp_valid;
  logic            rsp_bit;
  logic            bus_err;
  logic            busy;
  logic            data_in;
  logic            data_out;
  logic            data_out_oe;

  modport master (
    input  cmd_valid, cmd_op, cmd_bit, data_in,
    output cmd_ready, rsp_valid, rsp_bit, bus_err, busy, data_out, data_out_oe
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_bit, data_in,
    input  cmd_ready, rsp_valid, rsp_bit, bus_err, busy, data_out, data_out_oe
  );

endinterface

// File: rtl/owm_sync2.sv
// Two-flop synchronizer for the asynchronous DQ pin level.
//   clk, rst : clock, asynchronous active-high reset
//   d_i      : raw DQ level
//   q_o      : synchronized DQ level (resets high, matching an idle pulled-up bus)
module owm_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/owm_bus_master.sv
// 1-Wire bus master: runs one reset/presence sequence or one write/read bit
// slot per accepted command on the open-drain DQ line.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : owm_bus_master_if.master (command, response and DQ pad signals)
// All timing parameters are in clk cycles and must each be below 2**CNT_W.
module owm_bus_master
  import owm_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned T_RSTL = T_RSTL_DEF,
  parameter int unsigned T_PDS  = T_PDS_DEF,
  parameter int unsigned T_RSTH = T_RSTH_DEF,
  parameter int unsigned T_LOW1 = T_LOW1_DEF,
  parameter int unsigned T_LOW0 = T_LOW0_DEF,
  parameter int unsigned T_SMP  = T_SMP_DEF,
  parameter int unsigned T_SLOT = T_SLOT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  owm_bus_master_if.master bus
);

  localparam logic [CNT_W-1:0] RSTL_END = CNT_W'(T_RSTL - 1);
  localparam logic [CNT_W-1:0] PDS_AT   = CNT_W'(T_PDS);
  localparam logic [CNT_W-1:0] RSTH_END = CNT_W'(T_RSTH - 1);
  localparam logic [CNT_W-1:0] LOW1_END = CNT_W'(T_LOW1 - 1);
  localparam logic [CNT_W-1:0] LOW0_END = CNT_W'(T_LOW0 - 1);
  localparam logic [CNT_W-1:0] SMP_AT   = CNT_W'(T_SMP);
  localparam logic [CNT_W-1:0] SLOT_END = CNT_W'(T_SLOT - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [OP_W-1:0] op_q, op_d;
  logic            bit_q, bit_d;
  logic            smp_q, smp_d;
  logic            oe_q, oe_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_bit_q, rsp_bit_d;
  logic            bus_err_q, bus_err_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q;
  logic [CNT_W-1:0] slot_low_end;
  logic            dq_s;

  owm_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.data_in),
    .q_o (dq_s)
  );

  // Saturating increment: the counter must never wrap back onto a match value
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Only a write-0 holds the line for the long low time
  assign slot_low_end = (op_q == OP_WR && !bit_q) ? LOW0_END : LOW1_END;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      bit_q       <= 1'b0;
      smp_q       <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      bit_q       <= bit_d;
      smp_q       <= smp_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bit_q   <= rsp_bit_d;
      bus_err_q   <= bus_err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= ~cmd_ready_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    op_d        = op_q;
    bit_d       = bit_q;
    smp_d       = smp_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rsp_bit_d   = rsp_bit_q;
    bus_err_d   = 1'b0;
    cmd_ready_d = cmd_ready_q;

    unique case (state_q)
      IDLE: begin
        cnt_d       = '0;
        // Ready comes back one cycle after the response pulse
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d        = bus.cmd_op;
          bit_d       = bus.cmd_bit;
          smp_d       = 1'b0;
          cmd_ready_d = 1'b0;
          if (bus.cmd_op == OP_RST) begin
            state_d = RST_LOW;
            oe_d    = 1'b1;
          end else if (bus.cmd_op == OP_WR || bus.cmd_op == OP_RD) begin
            state_d = SLOT_LOW;
            oe_d    = 1'b1;
          end else begin
            // Reserved op completes immediately without touching the bus
            rsp_valid_d = 1'b1;
            rsp_bit_d   = 1'b0;
          end
        end
      end

      RST_LOW: begin
        if (cnt_q == RSTL_END) begin
          oe_d    = 1'b0;
          cnt_d   = '0;
          state_d = RST_WAIT;
        end
      end

      RST_WAIT: begin
        // A slave answers by pulling the line low
        if (cnt_q == PDS_AT) begin
          smp_d = ~dq_s;
        end
        if (cnt_q == RSTH_END) begin
          bus_err_d   = ~dq_s;
          rsp_valid_d = 1'b1;
          rsp_bit_d   = smp_q;
          state_d     = IDLE;
        end
      end

      SLOT_LOW: begin
        // A write-0 reaches the sample point while still driving low
        if (cnt_q == SMP_AT) begin
          smp_d = dq_s;
        end
        if (cnt_q == slot_low_end) begin
          oe_d    = 1'b0;
          state_d = SLOT_WAIT;
        end
      end

      SLOT_WAIT: begin
        if (cnt_q == SMP_AT) begin
          smp_d = dq_s;
        end
        if (cnt_q == SLOT_END) begin
          bus_err_d   = ~dq_s;
          rsp_valid_d = 1'b1;
          rsp_bit_d   = smp_q;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_bit     = rsp_bit_q;
  assign bus.bus_err     = bus_err_q;
  assign bus.data_out    = 1'b0;
  assign bus.data_out_oe = oe_q;

endmodule

// File: tb/tb_owm_bus_master.sv
// Self-checking bench for owm_bus_master with shortened timing. A stimulus
// process issues commands and plays a slave on DQ; expected responses and
// low-pulse widths are queued from a line-level model and checked by a
// separate monitor on the opposite clock edge.
module tb_owm_bus_master;
  import owm_pkg::*;

  localparam int CNT_W  = 16;
  localparam int T_RSTL = 2400;
  localparam int T_PDS  = 350;
  localparam int T_RSTH = 2050;
  localparam int T_LOW1 = 30;
  localparam int T_LOW0 = 300;
  localparam int T_SMP  = 75;
  localparam int T_SLOT = 325;

  localparam int K_IDLE  = 0;
  localparam int K_PULL  = 1;
  localparam int K_STUCK = 2;

  typedef struct {
    logic rsp_bit;
    logic bus_err;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slave_low = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  int   oe_q[$];

  int ncyc = 0;
  int acc_cyc = 0;
  int last_rsp_cyc = -100;
  int accept_gap = 0;
  int oe_w = 0;

  owm_bus_master_if bus();

  owm_bus_master #(
    .CNT_W (CNT_W),
    .T_RSTL(T_RSTL),
    .T_PDS (T_PDS),
    .T_RSTH(T_RSTH),
    .T_LOW1(T_LOW1),
    .T_LOW0(T_LOW0),
    .T_SMP (T_SMP),
    .T_SLOT(T_SLOT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Open-drain line with pull-up: low if master or slave pulls
  assign bus.data_in = ~(bus.data_out_oe | slave_low);

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, ncyc);
    end
  endfunction

  // Line level during cycle t after the accepting edge (1 = low)
  function automatic bit line_low(input logic [1:0] op, input logic b, input int kind,
                                  input int ws, input int we, input int t);
    int drv_len;
    if (op == OP_RST)            drv_len = T_RSTL;
    else if (op == OP_RSV)       drv_len = 0;
    else if (op == OP_WR && !b)  drv_len = T_LOW0;
    else                         drv_len = T_LOW1;
    return (t < drv_len) || (kind == K_STUCK) || (kind == K_PULL && t >= ws && t < we);
  endfunction

  // Monitor: accept tracking, response scoreboard, low-pulse widths
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (bus.cmd_valid && bus.cmd_ready) begin
      acc_cyc    = ncyc;
      accept_gap = ncyc - last_rsp_cyc;
    end
    if (bus.rsp_valid) begin
      last_rsp_cyc = ncyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=rsp_valid expected=none at cycle %0d", ncyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_bit", int'(bus.rsp_bit), int'(e.rsp_bit));
        chk("bus_err", int'(bus.bus_err), int'(e.bus_err));
        chk("latency", ncyc - acc_cyc, e.lat);
        chk("ready_in_rsp", int'(bus.cmd_ready), 0);
        chk("busy_in_rsp", int'(bus.busy), 1);
        chk("data_out", int'(bus.data_out), 0);
      end
    end else if (bus.bus_err) begin
      checks++;
      errors++;
      $display("FAIL bus_err_no_rsp actual=1 expected=0 at cycle %0d", ncyc);
    end
    if (bus.data_out_oe) begin
      oe_w++;
    end else if (oe_w != 0) begin
      if (oe_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_oe actual=%0d expected=none at cycle %0d", oe_w, ncyc);
      end else begin
        chk("oe_width", oe_w, oe_q.pop_front());
      end
      oe_w = 0;
    end
  end

  task automatic wait_ready(output bit ok);
    int g;
    g = 0;
    while (!bus.cmd_ready && g < 10000) begin
      @(posedge clk);
      #1;
      g++;
    end
    ok = bus.cmd_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1 at cycle %0d", ncyc);
    end
  endtask

  // Issue one command and play the slave for its full duration
  task automatic issue(input logic [1:0] op, input logic b, input int kind, input bit noise);
    int   ws, we, dur;
    exp_t e;
    bit   ok;
    wait_ready(ok);
    if (!ok) return;
    ws = 0;
    we = 0;
    if (kind == K_PULL) begin
      if (op == OP_RST) begin
        ws = T_RSTL + int'($urandom_range(300, 150));
        we = T_RSTL + int'($urandom_range(1200, 450));
      end else begin
        we = int'($urandom_range(250, 110));
      end
    end
    if (op == OP_RST) begin
      dur       = T_RSTL + T_RSTH;
      e.lat     = T_RSTL + T_RSTH + 1;
      e.rsp_bit = line_low(op, b, kind, ws, we, T_RSTL + T_PDS);
      e.bus_err = line_low(op, b, kind, ws, we, dur - 1);
      oe_q.push_back(T_RSTL);
    end else if (op == OP_RSV) begin
      dur       = 0;
      e.lat     = 1;
      e.rsp_bit = 1'b0;
      e.bus_err = 1'b0;
    end else begin
      dur       = T_SLOT;
      e.lat     = T_SLOT + 1;
      e.rsp_bit = !line_low(op, b, kind, ws, we, T_SMP);
      e.bus_err = line_low(op, b, kind, ws, we, dur - 1);
      oe_q.push_back((op == OP_WR && !b) ? T_LOW0 : T_LOW1);
    end
    exp_q.push_back(e);

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_bit   = b;
    slave_low     = (kind == K_STUCK);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    for (int t = 0; t < dur; t++) begin
      slave_low = (kind == K_STUCK) || (kind == K_PULL && t >= ws && t < we);
      if (noise) begin
        bus.cmd_valid = (t >= 5 && t < 40);
        bus.cmd_op    = OP_RSV;
      end
      @(posedge clk);
      #1;
    end
    slave_low     = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  // Bound on total run time
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished at cycle %0d", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    int         r, k, kind;
    bit         ok;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_bit   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_oe", int'(bus.data_out_oe), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_bit", int'(bus.rsp_bit), 0);
    chk("rst_bus_err", int'(bus.bus_err), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;

    // Reset with presence, then with no slave
    issue(OP_RST, 1'b0, K_PULL, 1'b0);
    issue(OP_RST, 1'b0, K_IDLE, 1'b0);

    // Write 1 then write 0 back to back
    issue(OP_WR, 1'b1, K_IDLE, 1'b0);
    issue(OP_WR, 1'b0, K_IDLE, 1'b0);
    chk("b2b_accept_gap", accept_gap, 1);

    // Read with slave holding low, read idle, read on stuck line
    issue(OP_RD, 1'b0, K_PULL, 1'b0);
    issue(OP_RD, 1'b0, K_IDLE, 1'b0);
    issue(OP_RD, 1'b0, K_STUCK, 1'b0);

    // Reserved op, then a slot with cmd_valid toggling while busy
    issue(OP_RSV, 1'b0, K_IDLE, 1'b0);
    issue(OP_WR, 1'b1, K_IDLE, 1'b1);

    // Async reset part way through the reset low time
    wait_ready(ok);
    if (ok) begin
      oe_q.push_back(1000);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_RST;
      bus.cmd_bit   = 1'b0;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (1000) @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      chk("abort_oe", int'(bus.data_out_oe), 0);
      chk("abort_ready", int'(bus.cmd_ready), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (T_RSTH + 20) @(posedge clk);
      #1;
      chk("abort_pending_rsp", exp_q.size(), 0);
    end

    // Randomized command mix
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(9, 0));
      if (r == 0)      op = OP_RST;
      else if (r == 1) op = OP_RSV;
      else if (r < 6)  op = OP_WR;
      else             op = OP_RD;
      k = int'($urandom_range(5, 0));
      if (op == OP_RSV) kind = K_IDLE;
      else if (k == 0)  kind = K_STUCK;
      else if (k < 3)   kind = K_PULL;
      else              kind = K_IDLE;
      issue(op, 1'($urandom_range(1, 0)), kind, 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("rsp_queue_drained", exp_q.size(), 0);
    chk("oe_queue_drained", oe_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
